// File: rtl/i2c_pkg.sv
// Shared definitions for the clocked I2C target: FSM state encoding,
// ACK/NACK bus levels and the input synchronizer depth.
package i2c_pkg;

  localparam int SYNC_DEPTH = 2;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_FETCH     = 4'd7,
    ST_RDATA     = 4'd8,
    ST_RDATA_ACK = 4'd9,
    ST_IGNORE    = 4'd10
  } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus one history flop; emits registered single-cycle
// SCL rise/fall and START/STOP pulses, three clk after the pin edge.
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop,
  output logic o_sda
);

  logic [SYNC_DEPTH-1:0] r_scl_sync;
  logic [SYNC_DEPTH-1:0] r_sda_sync;
  logic                  r_scl_hist;
  logic                  r_sda_hist;
  logic                  r_scl_rise;
  logic                  r_scl_fall;
  logic                  r_start;
  logic                  r_stop;
  logic                  w_scl;
  logic                  w_sda;

  assign w_scl = r_scl_sync[SYNC_DEPTH-1];
  assign w_sda = r_sda_sync[SYNC_DEPTH-1];

  // Synchronize the pins and register the edge/condition pulses (idle bus is high).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= {SYNC_DEPTH{1'b1}};
      r_sda_sync <= {SYNC_DEPTH{1'b1}};
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_DEPTH-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_DEPTH-2:0], i_sda};
      r_scl_hist <= w_scl;
      r_sda_hist <= w_sda;
      r_scl_rise <= w_scl & ~r_scl_hist;
      r_scl_fall <= ~w_scl & r_scl_hist;
      r_start    <= w_scl & r_scl_hist & r_sda_hist & ~w_sda;
      r_stop     <= w_scl & r_scl_hist & ~r_sda_hist & w_sda;
    end
  end

  assign o_scl_rise = r_scl_rise;
  assign o_scl_fall = r_scl_fall;
  assign o_start    = r_start;
  assign o_stop     = r_stop;
  assign o_sda      = r_sda_hist;

endmodule

// File: rtl/i2c_sram_target.sv
// I2C target bridging the bus to a single-port synchronous SRAM.
// Optional macro I2C_AUTOINC_EN: advance the pointer after every written or fetched byte.
module i2c_sram_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCL_I,
  input  logic              SDA_I,
  output logic              SCL_O,
  output logic              SDA_O,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;
  logic w_sda;

  state_t            r_state;
  state_t            r_ret;
  logic [3:0]        r_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_tx;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_rw;
  logic              r_mack;
  logic              r_fph;
  logic              r_sda_o;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [7:0]        r_mem_wdata;
  logic              r_mem_we;
  logic              r_mem_re;
  logic              r_busy;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .i_scl      (SCL_I),
    .i_sda      (SDA_I),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop),
    .o_sda      (w_sda)
  );

  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
`ifdef I2C_AUTOINC_EN
    return p + {{(ADDR_W-1){1'b0}}, 1'b1};
`else
    return p;
`endif
  endfunction

  // Transfer FSM; the read fetch runs inside the ACK low phase, so FETCH
  // returns to whichever ACK state launched it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ret       <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_shift     <= 8'h00;
      r_tx        <= 8'h00;
      r_ptr       <= {ADDR_W{1'b0}};
      r_rw        <= 1'b0;
      r_mack      <= I2C_NACK;
      r_fph       <= 1'b0;
      r_sda_o     <= I2C_NACK;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= 8'h00;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      if (w_stop) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_sda_o <= I2C_NACK;
        r_cnt   <= 4'd0;
      end else if (w_start) begin
        r_state <= ST_ADDR;
        r_sda_o <= I2C_NACK;
        r_cnt   <= 4'd0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt <= 4'd0;
          end
          ST_ADDR: begin
            if (w_scl_rise && r_cnt < 4'd8) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_cnt <= 4'd0;
              r_rw  <= r_shift[0];
              if (r_shift[7:1] == SLAVE_ADDR) begin
                r_busy  <= 1'b1;
                r_sda_o <= I2C_ACK;
                if (r_shift[0]) begin
                  r_mem_re   <= 1'b1;
                  r_mem_addr <= r_ptr;
                  r_fph      <= 1'b0;
                  r_ret      <= ST_ADDR_ACK;
                  r_state    <= ST_FETCH;
                end else begin
                  r_state <= ST_ADDR_ACK;
                end
              end else begin
                r_busy  <= 1'b0;
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              if (r_rw) begin
                r_sda_o <= r_tx[7];
                r_tx    <= {r_tx[6:0], 1'b0};
                r_cnt   <= 4'd1;
                r_state <= ST_RDATA;
              end else begin
                r_sda_o <= I2C_NACK;
                r_cnt   <= 4'd0;
                r_state <= ST_PTR;
              end
            end
          end
          ST_PTR, ST_WDATA: begin
            if (w_scl_rise && r_cnt < 4'd8) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_cnt   <= 4'd0;
              r_sda_o <= I2C_ACK;
              if (r_state == ST_PTR) begin
                r_ptr   <= r_shift;
                r_state <= ST_PTR_ACK;
              end else begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_ptr;
                r_mem_wdata <= r_shift;
                r_ptr       <= next_ptr(r_ptr);
                r_state     <= ST_WDATA_ACK;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_sda_o <= I2C_NACK;
              r_cnt   <= 4'd0;
              r_state <= ST_WDATA;
            end
          end
          ST_FETCH: begin
            if (!r_fph) begin
              r_fph <= 1'b1;
            end else begin
              r_fph   <= 1'b0;
              r_tx    <= mem_rdata;
              r_ptr   <= next_ptr(r_ptr);
              r_state <= r_ret;
            end
          end
          ST_RDATA: begin
            if (w_scl_fall) begin
              if (r_cnt == 4'd8) begin
                r_sda_o    <= I2C_NACK;
                r_cnt      <= 4'd0;
                r_mem_re   <= 1'b1;
                r_mem_addr <= r_ptr;
                r_fph      <= 1'b0;
                r_ret      <= ST_RDATA_ACK;
                r_state    <= ST_FETCH;
              end else begin
                r_sda_o <= r_tx[7];
                r_tx    <= {r_tx[6:0], 1'b0};
                r_cnt   <= r_cnt + 4'd1;
              end
            end
          end
          ST_RDATA_ACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda;
            end else if (w_scl_fall) begin
              if (r_mack == I2C_ACK) begin
                r_sda_o <= r_tx[7];
                r_tx    <= {r_tx[6:0], 1'b0};
                r_cnt   <= 4'd1;
                r_state <= ST_RDATA;
              end else begin
                r_sda_o <= I2C_NACK;
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_IGNORE: begin
            r_sda_o <= I2C_NACK;
          end
          default: begin
            r_sda_o <= I2C_NACK;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign SCL_O     = 1'b1;
  assign SDA_O     = r_sda_o;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_re    = r_mem_re;
  assign busy      = r_busy;

endmodule

// File: doc/i2c_sram_target.md
# i2c_sram_target

System-clocked I2C target that bridges the two-wire bus to a single-port synchronous SRAM. It oversamples SCL/SDA with `clk`, detects START/STOP, matches a 7-bit device address, and decodes the transfer:
- Write transfers: first byte is the memory pointer; subsequent bytes are written to SRAM.
- Read transfers: bytes are streamed out of SRAM.

It is the clocked responder counterpart to the team's I2C master and sits between the bus pins and the SRAM macro.

## Interface
- `SLAVE_ADDR`, 7'h50, 7-bit device address this target acknowledges.
- `ADDR_W`, 8, SRAM address width; memory pointer width.
- `clk`  in  1  system clock; SCL high and low phases each ≥ 8 `clk` periods.
- `rst`  in  1  asynchronous, active-low reset.
- `SCL_I`  in  1  bus SCL, asynchronous to `clk`.
- `SDA_I`  in  1  bus SDA, asynchronous to `clk`.
- `SCL_O`  out  1  SCL open-drain control; constant 1 (released); no clock stretching.
- `SDA_O`  out  1  SDA open-drain control; 0 = drive low, 1 = release.
- `mem_addr`  out  ADDR_W  SRAM address.
- `mem_wdata`  out  8  SRAM write data.
- `mem_we`  out  1  single-cycle write strobe.
- `mem_re`  out  1  single-cycle read strobe; `mem_rdata` is valid on the next `clk`.
- `mem_rdata`  in  8  SRAM read data.
- `busy`  out  1  high from an addressed START until STOP or abort.

## Operation
**Input conditioning.** `SCL_I` and `SDA_I` pass through a 2-flop synchronizer plus one history flop.
- START = SDA falls while SCL is high.
- STOP = SDA rises while SCL is high.
- Data is sampled on the detected SCL rise.
- `SDA_O` changes only on the `clk` after a detected SCL fall.

**States:**
- IDLE: wait for START.
- ADDR: shift 8 bits, MSB first; bit 0 is R/W.
- ADDR_ACK
  - Address match: drive ACK (`SDA_O` = 0) for one SCL period. Write → PTR. Read → FETCH.
  - Mismatch: `SDA_O` stays 1; go to IGNORE.
- PTR: shift 8 bits; load the pointer; then PTR_ACK.
- PTR_ACK: ACK; then WDATA.
- WDATA: shift 8 bits; then WDATA_ACK.
- WDATA_ACK: ACK, pulse `mem_we` at `mem_addr` = pointer, advance the pointer; then WDATA.
- FETCH: pulse `mem_re` at the pointer; capture `mem_rdata` one `clk` later into the TX shift register; advance the pointer; then RDATA. FETCH must finish inside the current ACK SCL-low phase.
- RDATA: drive 8 bits MSB first; then RDATA_ACK.
- RDATA_ACK: release SDA and sample the master's ACK/NACK.
  - Master ACK (0): go to FETCH.
  - Master NACK (1): go to IGNORE.
- IGNORE: `SDA_O` = 1; wait for START or STOP.

**Bus conditions and boundaries:**
- START in any state: go to ADDR (repeated START). A partial byte is discarded and nothing is written. The pointer is retained.
- STOP in any state: go to IDLE, clear `busy`, discard any partial byte.
- Pointer wraps 2^ADDR_W−1 → 0.
- `SDA_O` is never driven during a STOP.

**Reset values:** `SDA_O` = 1, `SCL_O` = 1, `mem_we` = 0, `mem_re` = 0, `mem_addr` = 0, `mem_wdata` = 0, `busy` = 0, pointer = 0, state = IDLE. Reset mid-transfer releases SDA immediately.

## Timing
- Bus edge → internal detect: 3 `clk` (2 synchronizer + 1 edge).
- SCL fall detect → `SDA_O` update: 1 `clk`; total 4 `clk` after the pin edge.
- `mem_we` asserts 1 `clk` after the SCL fall that starts WDATA_ACK.
- `mem_re` asserts 1 `clk` after the SCL fall that starts ADDR_ACK or RDATA_ACK; data is captured 1 `clk` later.
- `mem_we` and `mem_re` are never high in the same cycle. Each pulses exactly once per byte.

## Configuration
`I2C_AUTOINC_EN`:
- Defined: the pointer increments after every written or fetched byte.
- Undefined: the pointer changes only in PTR. Repeated writes hit the same address; reads return the same location.

## Structure
- Shared package `i2c_pkg`: state enumeration, `I2C_ACK` = 1'b0, `I2C_NACK` = 1'b1, synchronizer depth constant.
- One sub-module, `i2c_bus_sync`: synchronizers plus the SCL rise/fall and START/STOP detect pulses.

## Test plan
- Write 0xA0, ptr 0x10, data 0x5A, 0xC3, STOP → ACK on all 4 bytes; `mem_we` at 0x10 = 0x5A and 0x11 = 0xC3 (0x10 twice without `I2C_AUTOINC_EN`).
- Write ptr 0x10, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP → `SDA_O` carries mem[0x10], mem[0x11]; IGNORE, then IDLE.
- Address 0xA2 (mismatch) → `SDA_O` = 1 throughout; no `mem_we`/`mem_re`; `busy` = 0.
- Ptr 0xFF, write 3 bytes → writes land at 0xFF, 0x00, 0x01.
- STOP after 5 bits of a data byte → no `mem_we`; next write transfer proceeds normally.
- Assert `rst` mid-RDATA while driving 0 → `SDA_O` = 1 asynchronously; all outputs at reset values.
